irq_front_end: RTL

- Conditions the three raw interrupt buttons and delivers prioritised, nestable interrupt requests to the CPU core's pipeline-flush and EPC logic.
- Sits directly upstream of the core: it replaces direct button sampling and drives the core's `interrupted` pulse and `interruptOut` LEDs.
- Consumes the core's interrupt-return indication (eret retired in EX) to pop the in-service level.

---
 rtl/irq_front_end.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/irq_front_end.sv
// rtl/irq_front_end.sv - debounced, prioritised, nestable interrupt front end (optional IRQ_MASK_EN adds maskIn)
module irq_front_end #(
    parameter int NUM_LINES       = 3,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLDOFF_CYCLES  = 2
) (
    input  logic                 clock,
    input  logic                 resetButton,
    input  logic [NUM_LINES-1:0] rawRequest,
    input  logic                 enable,
    input  logic                 interruptEnd,
`ifdef IRQ_MASK_EN
    input  logic [NUM_LINES-1:0] maskIn,
`endif
    output logic                 interrupted,
    output logic [1:0]           interruptLevel,
    output logic [NUM_LINES-1:0] interruptOut,
    output logic [NUM_LINES-1:0] pendingOut,
    output logic                 overflow
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [NUM_LINES-1:0] sync1;
    logic [NUM_LINES-1:0] sync2;
    logic [NUM_LINES-1:0] level;
    logic [NUM_LINES-1:0] flip;
    logic [NUM_LINES-1:0] rise;
    logic [CW-1:0]        cnt [NUM_LINES];
    logic [NUM_LINES-1:0] pending;
    logic [NUM_LINES-1:0] in_service;
    logic [NUM_LINES-1:0] svc_popped;
    logic [NUM_LINES-1:0] eligible;
    logic [NUM_LINES-1:0] dispatch_mask;
    logic [HW-1:0]        holdoff;
    logic [1:0]           top_svc;
    logic [1:0]           cur_level;
    logic [1:0]           cand;
    logic [1:0]           cand_q;
    logic                 cand_valid;
    logic                 dispatch;
    logic                 ovf;

    // Two-flop synchroniser for the asynchronous buttons
    always_ff @(posedge clock or negedge resetButton) begin
        if (!resetButton) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= rawRequest;
            sync2 <= sync1;
        end
    end

    // A line flips once its sample has disagreed with the level for DEBOUNCE_CYCLES cycles
    always_comb begin
        flip = '0;
        rise = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            flip[i] = (sync2[i] != level[i]) && (cnt[i] == CNT_LAST);
            rise[i] = flip[i] && sync2[i];
        end
    end

    // Debounce counters and debounced levels
    always_ff @(posedge clock or negedge resetButton) begin
        if (!resetButton) begin
            level <= '0;
            for (int i = 0; i < NUM_LINES; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LINES; i++) begin
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (flip[i]) begin
                    cnt[i]   <= '0;
                    level[i] <= ~level[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Interrupt return pops first; the candidate is then judged against the popped mask
    always_comb begin
        top_svc = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (in_service[i]) top_svc = 2'(i);
        end
        svc_popped = in_service;
        if (interruptEnd && (in_service != '0)) svc_popped[top_svc] = 1'b0;
        cur_level = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (svc_popped[i]) cur_level = 2'(i);
        end
`ifdef IRQ_MASK_EN
        eligible = pending & ~maskIn;
`else
        eligible = pending;
`endif
        cand       = '0;
        cand_valid = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (eligible[i] && ((svc_popped == '0) || (2'(i) > cur_level))) begin
                cand       = 2'(i);
                cand_valid = 1'b1;
            end
        end
    end

    // Dispatch FSM next-state and dispatch strobe
    always_comb begin
        state_next = state;
        dispatch   = 1'b0;
        case (state)
            IDLE: begin
                if (cand_valid && enable && (holdoff == '0)) begin
                    state_next = DISPATCH;
                    dispatch   = 1'b1;
                end
            end
            DISPATCH: state_next = HOLD;
            HOLD: begin
                if (holdoff <= HW'(1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        dispatch_mask = dispatch ? (NUM_LINES'(1) << cand) : '0;
    end

    // FSM state register and latched dispatch level
    always_ff @(posedge clock or negedge resetButton) begin
        if (!resetButton) begin
            state  <= IDLE;
            cand_q <= '0;
        end else begin
            state <= state_next;
            if (dispatch) cand_q <= cand;
        end
    end

    // Holdoff counter covers the pipeline flush window after each dispatch
    always_ff @(posedge clock or negedge resetButton) begin
        if (!resetButton) begin
            holdoff <= '0;
        end else if (state == DISPATCH) begin
            holdoff <= HOLD_LOAD;
        end else if (holdoff != '0) begin
            holdoff <= holdoff - HW'(1);
        end
    end

    // Pending, in-service and sticky overflow; a dispatch clears before a same-cycle edge re-sets
    always_ff @(posedge clock or negedge resetButton) begin
        if (!resetButton) begin
            pending    <= '0;
            in_service <= '0;
            ovf        <= 1'b0;
        end else begin
            pending    <= (pending & ~dispatch_mask) | rise;
            in_service <= svc_popped | dispatch_mask;
            ovf        <= ovf | (|(rise & pending & ~dispatch_mask));
        end
    end

    assign interrupted    = (state == DISPATCH);
    assign interruptLevel = cand_q;
    assign interruptOut   = in_service;
    assign pendingOut     = pending;
    assign overflow       = ovf;

endmodule
